// File: rtl/tnn_feature_quantizer.sv
// Quantizes raw feature samples to 3-bit bin codes and packs five codes into one classifier input vector.
// Latency: m_valid rises one cycle after the 5th beat of a frame is accepted.
// Backpressure: beats 0..3 are always accepted; the 5th beat stalls only while the output holds an undrained vector.
module tnn_feature_quantizer #(
    parameter int RAW_W  = 12,
    parameter int N_FEAT = 5,
    parameter int Q_W    = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_we,
    input  logic [2:0]              cfg_feat,
    input  logic [2:0]              cfg_idx,
    input  logic [RAW_W-1:0]        cfg_thr,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [RAW_W-1:0]        s_data,
    input  logic                    s_last,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [N_FEAT*Q_W-1:0]   m_vec,
    output logic                    err_frame,
    output logic [15:0]             frame_cnt
);

    localparam int N_THR = (1 << Q_W) - 1;
    localparam int IDX_W = $clog2(N_FEAT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FEAT - 1);

    logic [N_FEAT-1:0][N_THR-1:0][RAW_W-1:0] thr;
    logic [N_THR-1:0][RAW_W-1:0]             sel_thr;
    logic [N_FEAT-2:0][Q_W-1:0]              coll;
    logic [Q_W-1:0]                          code;
    logic [IDX_W-1:0]                        idx;
    logic [IDX_W-1:0]                        idx_nxt;
    logic                                    accept;
    logic                                    at_last;
    logic                                    load;
    logic                                    frame_err;

    // Threshold table: reset to evenly spaced bins; writes with an out-of-range feature or index match no entry and are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int f = 0; f < N_FEAT; f++) begin
                for (int k = 0; k < N_THR; k++) begin
                    thr[f][k] <= RAW_W'(k + 1) << (RAW_W - 3);
                end
            end
        end else begin
            for (int f = 0; f < N_FEAT; f++) begin
                for (int k = 0; k < N_THR; k++) begin
                    if (cfg_we && cfg_feat == 3'(f) && cfg_idx == 3'(k)) begin
                        thr[f][k] <= cfg_thr;
                    end
                end
            end
        end
    end

    // Pick the threshold row of the feature currently being collected.
    always_comb begin
        sel_thr = thr[0];
        for (int f = 0; f < N_FEAT; f++) begin
            if (idx == IDX_W'(f)) begin
                sel_thr = thr[f];
            end
        end
    end

    // Code is a population count of thresholds at or below the sample, so unordered thresholds need no special handling.
    always_comb begin
        code = '0;
        for (int k = 0; k < N_THR; k++) begin
            if (s_data >= sel_thr[k]) begin
                code = code + Q_W'(1);
            end
        end
    end

    // Handshake and framing decisions for the current beat.
    always_comb begin
        at_last   = (idx == LAST_IDX);
        s_ready   = !(at_last && m_valid && !m_ready);
        accept    = s_valid && s_ready;
        load      = accept && at_last;
        frame_err = accept && (at_last ? !s_last : s_last);
        idx_nxt   = idx;
        if (accept) begin
            idx_nxt = (at_last || s_last) ? '0 : idx + IDX_W'(1);
        end
    end

    // Collect buffer; a short frame just rewinds idx, and stale slots are overwritten before the next vector can form.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx  <= '0;
            coll <= '0;
        end else begin
            idx <= idx_nxt;
            if (accept && !at_last) begin
                for (int f = 0; f < N_FEAT - 1; f++) begin
                    if (idx == IDX_W'(f)) begin
                        coll[f] <= code;
                    end
                end
            end
        end
    end

    // Output register, error pulse and emitted-vector counter; a load wins over a simultaneous drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid   <= 1'b0;
            m_vec     <= '0;
            err_frame <= 1'b0;
            frame_cnt <= '0;
        end else begin
            err_frame <= frame_err;
            if (m_valid && m_ready) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (load) begin
                m_vec   <= {code, coll};
                m_valid <= 1'b1;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule
